// File: rtl/rptr_empty_ctrl.sv
// rptr_empty_ctrl: read-side pointer and empty-flag control for an asynchronous FIFO
//   rclk       read-domain clock, all state rising-edge
//   rrst_n     asynchronous active-low reset
//   rinc       pop request from the consumer
//   aempty_n   asynchronous almost-empty from the pointer comparator, active-low
//   raddr      binary read address to the dual-port memory
//   rptr       Gray-coded read pointer to the comparator
//   rempty     FIFO empty, asserted asynchronously, released after two rclk edges
//   rvalid     memory read data valid, one cycle after an accepted pop
//   runderflow sticky flag: pop attempted while empty
module rptr_empty_ctrl #(
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic                aempty_n,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE-1:0] rptr,
    output logic                rempty,
    output logic                rvalid,
    output logic                runderflow
);
    logic [ADDRSIZE-1:0] rbin, rbnext;
    logic                pop, rempty2, aset_n;

    assign pop    = rinc & ~rempty;
    assign rbnext = rbin + ADDRSIZE'(pop);
    assign raddr  = rbin;
    // Either reset or the comparator's almost-empty forces the flag chain to empty at once
    assign aset_n = rrst_n & aempty_n;

    always_ff @(posedge rclk or negedge rrst_n)
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rvalid     <= 1'b0;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbnext;
            rptr       <= (rbnext >> 1) ^ rbnext;
            rvalid     <= pop;
            runderflow <= runderflow | (rinc & rempty);
        end

    // Two-flop release synchroniser: set asynchronously, cleared one stage per edge
    always_ff @(posedge rclk or negedge aset_n)
        if (!aset_n) {rempty, rempty2} <= 2'b11;
        else         {rempty, rempty2} <= {rempty2, 1'b0};
endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// tb_rptr_empty_ctrl: directed self-checking bench for rptr_empty_ctrl
module tb_rptr_empty_ctrl;
    logic       rclk = 1'b0;
    logic       rrst_n, rinc, aempty_n;
    logic [3:0] raddr, rptr, prev;
    logic       rempty, rvalid, runderflow;
    int         vectors = 0, miscompares = 0;
    int         gray_tab [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    rptr_empty_ctrl #(.ADDRSIZE(4)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .aempty_n(aempty_n),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .rvalid(rvalid),
        .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        rrst_n = 1'b0; rinc = 1'b0; aempty_n = 1'b1;
        repeat (2) tick();
        check("rst_raddr", raddr, 0);
        check("rst_rptr", rptr, 0);
        check("rst_rempty", rempty, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_unf", runderflow, 0);
        // release reset mid-cycle, no pops
        #3 rrst_n = 1'b1;
        tick();
        check("rel_e1_rempty", rempty, 1);
        tick();
        check("rel_e2_rempty", rempty, 0);
        check("rel_raddr", raddr, 0);
        check("rel_rptr", rptr, 0);
        // 16 consecutive pops with wrap
        rinc = 1'b1;
        prev = rptr;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("pop_raddr", raddr, (i + 1) % 16);
            check("pop_rptr", rptr, gray_tab[i]);
            check("pop_ham", $countones(rptr ^ prev), 1);
            check("pop_rvalid", rvalid, 1);
            prev = rptr;
        end
        rinc = 1'b0;
        tick();
        check("pop_end_rvalid", rvalid, 0);
        check("pop_end_raddr", raddr, 0);
        check("pre_unf", runderflow, 0);
        // asynchronous empty assertion mid-cycle, blocked pop
        #3 aempty_n = 1'b0;
        #1 check("async_rempty", rempty, 1);
        rinc = 1'b1;
        tick();
        check("blk_raddr", raddr, 0);
        check("blk_rvalid", rvalid, 0);
        check("blk_unf", runderflow, 1);
        rinc = 1'b0;
        // glitchy release restarts the deassert count
        aempty_n = 1'b1;
        tick();
        check("gl_e1", rempty, 1);
        aempty_n = 1'b0;
        #1 check("gl_low", rempty, 1);
        tick();
        check("gl_e2", rempty, 1);
        aempty_n = 1'b1;
        tick();
        check("gl_e3", rempty, 1);
        tick();
        check("gl_e4", rempty, 0);
        check("sticky_unf", runderflow, 1);
        // reset coincident with a pop after 5 pops
        rinc = 1'b1;
        repeat (5) tick();
        check("p5_raddr", raddr, 5);
        check("p5_rvalid", rvalid, 1);
        #2 rrst_n = 1'b0;
        #1;
        check("mrst_raddr", raddr, 0);
        check("mrst_rptr", rptr, 0);
        check("mrst_rempty", rempty, 1);
        check("mrst_rvalid", rvalid, 0);
        check("mrst_unf", runderflow, 0);
        tick();
        check("mrst_hold_raddr", raddr, 0);
        check("mrst_hold_rvalid", rvalid, 0);
        // rinc held high through empty/non-empty transitions
        #3 rrst_n = 1'b1;
        tick();
        check("hold_e1_raddr", raddr, 0);
        check("hold_e1_unf", runderflow, 1);
        tick();
        check("hold_e2_raddr", raddr, 0);
        check("hold_e2_rempty", rempty, 0);
        tick();
        check("hold_e3_raddr", raddr, 1);
        check("hold_e3_rvalid", rvalid, 1);
        tick();
        check("hold_e4_raddr", raddr, 2);
        #3 aempty_n = 1'b0;
        tick();
        check("hold_e5_raddr", raddr, 2);
        check("hold_e5_rvalid", rvalid, 0);
        aempty_n = 1'b1;
        repeat (2) tick();
        check("hold_e7_raddr", raddr, 2);
        // pop accepted on the last non-empty edge, then empty falls just after it
        @(posedge rclk);
        #1 aempty_n = 1'b0;
        #1;
        check("late_raddr", raddr, 3);
        check("late_rptr", rptr, 2);
        check("late_rempty", rempty, 1);
        tick();
        check("late_blk_raddr", raddr, 3);
        check("late_blk_rvalid", rvalid, 0);
        rinc = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
